// File: rtl/branch_predictor_if.sv
// Fetcher / ROB / global-control bundle for the branch direction predictor.
// master: the environment (fetcher, ROB, global ready); slave: the predictor.
interface branch_predictor_if;
    logic        rdy;
    logic        rollback_sign;

    logic        enable_sign_from_fch;
    logic [31:0] pc_from_fch;
    logic [31:0] inst_from_fch;
    logic        valid_sign_to_fch;
    logic        predicted_jump_sign_to_fch;
    logic [31:0] predicted_pc_to_fch;

    logic        enable_sign_from_rob;
    logic        jump_sign_from_rob;
    logic [31:0] pc_from_rob;

    modport master (
        output rdy,
        output rollback_sign,
        output enable_sign_from_fch,
        output pc_from_fch,
        output inst_from_fch,
        input  valid_sign_to_fch,
        input  predicted_jump_sign_to_fch,
        input  predicted_pc_to_fch,
        output enable_sign_from_rob,
        output jump_sign_from_rob,
        output pc_from_rob
    );

    modport slave (
        input  rdy,
        input  rollback_sign,
        input  enable_sign_from_fch,
        input  pc_from_fch,
        input  inst_from_fch,
        output valid_sign_to_fch,
        output predicted_jump_sign_to_fch,
        output predicted_pc_to_fch,
        input  enable_sign_from_rob,
        input  jump_sign_from_rob,
        input  pc_from_rob
    );
endinterface

// File: rtl/branch_predictor.sv
// Branch direction predictor: table of 2-bit saturating counters indexed by
// pc[BHT_INDEX_BITS+1:2], trained by committed branch outcomes from the ROB,
// queried by the fetcher with a one-cycle registered response.
// Optional build macro PREDICTOR_STATS_EN adds update / misprediction counters.
module branch_predictor #(
    parameter int          BHT_INDEX_BITS = 8,
    parameter logic [1:0]  COUNTER_INIT   = 2'd1
) (
    input  logic                clk,
    input  logic                rst,
    branch_predictor_if.slave   bp
`ifdef PREDICTOR_STATS_EN
    ,
    output logic [31:0]         stat_update_cnt,
    output logic [31:0]         stat_miss_cnt
`endif
);

    localparam int BHT_ENTRIES = 1 << BHT_INDEX_BITS;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [1:0]                bht [BHT_ENTRIES];

    logic [BHT_INDEX_BITS-1:0] upd_idx;
    logic [BHT_INDEX_BITS-1:0] qry_idx;
    logic                      update_fire;
    logic                      query_accept;
    logic [1:0]                upd_old;
    logic [1:0]                upd_new;
    logic [1:0]                qry_ctr;

    logic [6:0]                opcode;
    logic [31:0]               j_imm;
    logic [31:0]               b_imm;
    logic [31:0]               pc_plus4;
    logic                      next_jump;
    logic [31:0]               next_pc;

    logic                      valid_q;
    logic                      jump_q;
    logic [31:0]               pc_q;

    logic                      unused_pc_bits;

    assign upd_idx      = bp.pc_from_rob[BHT_INDEX_BITS+1:2];
    assign qry_idx      = bp.pc_from_fch[BHT_INDEX_BITS+1:2];
    assign update_fire  = bp.rdy && bp.enable_sign_from_rob;
    // A query raised together with rollback belongs to the squashed path.
    assign query_accept = bp.rdy && bp.enable_sign_from_fch && !bp.rollback_sign;

    assign unused_pc_bits = ^{bp.pc_from_rob[31:BHT_INDEX_BITS+2], bp.pc_from_rob[1:0]};

    // Saturating next value of the counter addressed by the committing branch.
    always_comb begin
        upd_old = bht[upd_idx];
        upd_new = upd_old;
        if (bp.jump_sign_from_rob) begin
            if (upd_old != 2'd3) upd_new = upd_old + 2'd1;
        end else begin
            if (upd_old != 2'd0) upd_new = upd_old - 2'd1;
        end
    end

    // Counter seen by the query, forwarding a same-cycle update to the same entry.
    always_comb begin
        qry_ctr = bht[qry_idx];
        if (update_fire && (upd_idx == qry_idx)) qry_ctr = upd_new;
    end

    // Instruction decode and target computation (all arithmetic mod 2^32).
    always_comb begin
        opcode   = bp.inst_from_fch[6:0];
        j_imm    = {{12{bp.inst_from_fch[31]}}, bp.inst_from_fch[19:12],
                    bp.inst_from_fch[20], bp.inst_from_fch[30:21], 1'b0};
        b_imm    = {{20{bp.inst_from_fch[31]}}, bp.inst_from_fch[7],
                    bp.inst_from_fch[30:25], bp.inst_from_fch[11:8], 1'b0};
        pc_plus4 = bp.pc_from_fch + 32'd4;
        next_jump = 1'b0;
        next_pc   = pc_plus4;
        case (opcode)
            OPC_JAL: begin
                next_jump = 1'b1;
                next_pc   = bp.pc_from_fch + j_imm;
            end
            OPC_BRANCH: begin
                next_jump = qry_ctr[1];
                next_pc   = qry_ctr[1] ? (bp.pc_from_fch + b_imm) : pc_plus4;
            end
            // JALR target is register-dependent; fall through and let the ROB fix it.
            OPC_JALR: begin
                next_jump = 1'b0;
                next_pc   = pc_plus4;
            end
            default: begin
                next_jump = 1'b0;
                next_pc   = pc_plus4;
            end
        endcase
    end

    // Counter table: async clear, trained on every applied ROB update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= COUNTER_INIT;
        end else if (update_fire) begin
            bht[upd_idx] <= upd_new;
        end
    end

    // Registered fetcher response; prediction fields hold when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            jump_q  <= 1'b0;
            pc_q    <= 32'd0;
        end else if (bp.rdy) begin
            valid_q <= query_accept;
            if (query_accept) begin
                jump_q <= next_jump;
                pc_q   <= next_pc;
            end
        end
    end

    assign bp.valid_sign_to_fch          = valid_q;
    assign bp.predicted_jump_sign_to_fch = jump_q;
    assign bp.predicted_pc_to_fch        = pc_q;

`ifdef PREDICTOR_STATS_EN
    // Update and misprediction counters; a miss compares against the pre-update counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_update_cnt <= 32'd0;
            stat_miss_cnt   <= 32'd0;
        end else if (update_fire) begin
            stat_update_cnt <= stat_update_cnt + 32'd1;
            if (upd_old[1] != bp.jump_sign_from_rob) stat_miss_cnt <= stat_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: table of vectors applied through a
// scoreboard queue, plus hand-written sequences for rdy stall and async reset.
module tb_branch_predictor;

    localparam logic [31:0] BEQ_P8  = 32'h00000463;
    localparam logic [31:0] BEQ_M8  = 32'hFE000CE3;
    localparam logic [31:0] JAL_P16 = 32'h0100006F;
    localparam logic [31:0] JAL_M4  = 32'hFFDFF06F;
    localparam logic [31:0] ADDI    = 32'h00000013;
    localparam logic [31:0] JALR    = 32'h00008067;

    typedef struct {
        logic        rdy;
        logic        q_en;
        logic [31:0] q_pc;
        logic [31:0] q_inst;
        logic        u_en;
        logic        u_jump;
        logic [31:0] u_pc;
        logic        rb;
        logic        e_valid;
        logic        e_jump;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic        valid;
        logic        jump;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    exp_t sb_q[$];
    vec_t vecs[$];

    branch_predictor_if bp ();

`ifdef PREDICTOR_STATS_EN
    logic [31:0] stat_update_cnt;
    logic [31:0] stat_miss_cnt;
`endif

    branch_predictor dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp.slave)
`ifdef PREDICTOR_STATS_EN
        ,
        .stat_update_cnt (stat_update_cnt),
        .stat_miss_cnt   (stat_miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (got timeout, want $finish)");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic q_en, input logic [31:0] q_pc, input logic [31:0] q_inst,
                                input logic u_en, input logic u_jump, input logic [31:0] u_pc,
                                input logic rb, input logic e_valid, input logic e_jump,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rdy = 1'b1;   v.q_en = q_en;       v.q_pc = q_pc;   v.q_inst = q_inst;
        v.u_en = u_en;  v.u_jump = u_jump;   v.u_pc = u_pc;   v.rb = rb;
        v.e_valid = e_valid; v.e_jump = e_jump; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic drive_idle();
        bp.rdy = 1'b1;
        bp.rollback_sign = 1'b0;
        bp.enable_sign_from_fch = 1'b0;
        bp.pc_from_fch = 32'd0;
        bp.inst_from_fch = 32'd0;
        bp.enable_sign_from_rob = 1'b0;
        bp.jump_sign_from_rob = 1'b0;
        bp.pc_from_rob = 32'd0;
    endtask

    // Drive one cycle, queue its expected response, compare after the edge.
    task automatic step(input string tag, input vec_t v);
        exp_t e;
        @(negedge clk);
        bp.rdy = v.rdy;
        bp.rollback_sign = v.rb;
        bp.enable_sign_from_fch = v.q_en;
        bp.pc_from_fch = v.q_pc;
        bp.inst_from_fch = v.q_inst;
        bp.enable_sign_from_rob = v.u_en;
        bp.jump_sign_from_rob = v.u_jump;
        bp.pc_from_rob = v.u_pc;
        e.valid = v.e_valid; e.jump = v.e_jump; e.pc = v.e_pc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s.scoreboard: got empty queue want one entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".valid"}, {31'd0, bp.valid_sign_to_fch}, {31'd0, e.valid});
            if (e.valid) begin
                chk({tag, ".jump"}, {31'd0, bp.predicted_jump_sign_to_fch}, {31'd0, e.jump});
                chk({tag, ".pc"}, bp.predicted_pc_to_fch, e.pc);
            end
        end
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_pass   = 0;
        drive_idle();
        rst = 1'b1;

        // All counters start at 1 (weakly not-taken).
        vecs.push_back(mk(1, 32'h100, BEQ_P8, 0, 0, 0, 0, 1, 0, 32'h104));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h100, 0, 0, 0, 0));               // 0x100: 2
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h100, 0, 0, 0, 0));               // 3
        vecs.push_back(mk(1, 32'h100, BEQ_P8, 0, 0, 0, 0, 1, 1, 32'h108));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h100, 0, 0, 0, 0));               // stays 3
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h100, 0, 0, 0, 0));               // 2
        vecs.push_back(mk(1, 32'h100, BEQ_P8, 0, 0, 0, 0, 1, 1, 32'h108));
        vecs.push_back(mk(1, 32'h100, BEQ_M8, 0, 0, 0, 0, 1, 1, 32'h0F8));
        vecs.push_back(mk(1, 32'h200, JAL_P16, 0, 0, 0, 0, 1, 1, 32'h210));
        vecs.push_back(mk(1, 32'h200, ADDI, 0, 0, 0, 0, 1, 0, 32'h204));
        vecs.push_back(mk(1, 32'h300, JALR, 0, 0, 0, 0, 1, 0, 32'h304));
        vecs.push_back(mk(1, 32'h0, JAL_M4, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFC));
        vecs.push_back(mk(1, 32'hFFFFFFFC, ADDI, 0, 0, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h500, BEQ_P8, 0, 0, 0, 0, 1, 1, 32'h508));    // aliases 0x100
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h100, 0, 0, 0, 0));               // 0x100: 1
        vecs.push_back(mk(1, 32'h100, BEQ_P8, 1, 1, 32'h100, 0, 1, 1, 32'h108)); // bypass -> 2
        vecs.push_back(mk(1, 32'h100, BEQ_P8, 1, 0, 32'h100, 0, 1, 0, 32'h104)); // bypass -> 1
        vecs.push_back(mk(1, 32'h100, BEQ_P8, 1, 1, 32'h100, 1, 0, 0, 0));    // rollback, -> 2
        vecs.push_back(mk(1, 32'h100, BEQ_P8, 0, 0, 0, 0, 1, 1, 32'h108));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h180, 0, 0, 0, 0));               // 0x180: 0
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h180, 0, 0, 0, 0));               // stays 0
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h180, 0, 0, 0, 0));               // 1
        vecs.push_back(mk(1, 32'h180, BEQ_P8, 0, 0, 0, 0, 1, 0, 32'h184));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h180, 0, 0, 0, 0));               // 2
        vecs.push_back(mk(1, 32'h180, BEQ_P8, 1, 0, 32'h100, 0, 1, 1, 32'h188)); // no bypass across index
        vecs.push_back(mk(1, 32'h100, BEQ_P8, 0, 0, 0, 0, 1, 0, 32'h104));    // 0x100 now 1
        vecs.push_back(mk(1, 32'h200, JAL_P16, 0, 0, 0, 0, 1, 1, 32'h210));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.valid", {31'd0, bp.valid_sign_to_fch}, 32'd0);
        chk("reset.jump", {31'd0, bp.predicted_jump_sign_to_fch}, 32'd0);
        chk("reset.pc", bp.predicted_pc_to_fch, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
`ifdef PREDICTOR_STATS_EN
            if (i == 2) begin
                chk("stat.update_cnt", stat_update_cnt, 32'd2);
                chk("stat.miss_cnt", stat_miss_cnt, 32'd1);
            end
`endif
        end

        // rdy low for 3 cycles with a query and a not-taken update on 0x180: nothing moves.
        for (int i = 0; i < 3; i++) begin
            v = mk(1, 32'h180, ADDI, 1, 0, 32'h180, 0, 1, 1, 32'h210);
            v.rdy = 1'b0;
            step($sformatf("stall%0d", i), v);
        end
        step("after_stall", mk(1, 32'h180, BEQ_P8, 0, 0, 0, 0, 1, 1, 32'h188));

        // Async reset mid-cycle clears outputs at once and restores counters.
        @(negedge clk);
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.valid", {31'd0, bp.valid_sign_to_fch}, 32'd0);
        chk("midrst.jump", {31'd0, bp.predicted_jump_sign_to_fch}, 32'd0);
        chk("midrst.pc", bp.predicted_pc_to_fch, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", mk(1, 32'h180, BEQ_P8, 0, 0, 0, 0, 1, 0, 32'h184));

        @(negedge clk);
        drive_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
